// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending-write counters gate issue
// until RAW sources retire, with a saturating stall counter and a sticky underflow flag.
module decode_hazard_scoreboard #(
  parameter int REGISTER_DEPTH  = 32,
  parameter int CNT_WIDTH       = 2,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] issue_rs1,
  input  logic                              issue_rs1_used,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] issue_rs2,
  input  logic                              issue_rs2_used,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] issue_rd,
  input  logic                              issue_rd_write,
  input  logic                              downstream_ready,
  output logic                              issue_accept,
  output logic                              stall,
  input  logic                              wb_valid,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] wb_rd,
  input  logic                              flush,
  output logic [$clog2(REGISTER_DEPTH):0]   busy_count,
  output logic [STALL_CNT_WIDTH-1:0]        stall_cycles,
  output logic                              underflow_err
);

  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]       cnt_q [REGISTER_DEPTH];
  logic [CNT_WIDTH-1:0]       cnt_d [REGISTER_DEPTH];
  logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic                       underflow_q, underflow_d;

  logic raw1, raw2, full, hazard;
  logic incEn, decEn;

  // Hazards look only at registered counts, so a same-cycle writeback never bypasses.
  always_comb begin
    raw1   = issue_rs1_used && (issue_rs1 != '0) && (cnt_q[issue_rs1] != '0);
    raw2   = issue_rs2_used && (issue_rs2 != '0) && (cnt_q[issue_rs2] != '0);
    full   = issue_rd_write && (issue_rd != '0) && (cnt_q[issue_rd] == CntMax);
    hazard = raw1 || raw2 || full;

    stall        = issue_valid && hazard && !flush;
    issue_accept = issue_valid && !hazard && downstream_ready && !flush;

    incEn = issue_accept && issue_rd_write && (issue_rd != '0);
    decEn = wb_valid && (wb_rd != '0);
  end

  always_comb begin
    logic incHit;
    logic decHit;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    incHit      = 1'b0;
    decHit      = 1'b0;
    cnt_d[0]    = '0;
    for (int i = 1; i < REGISTER_DEPTH; i++) begin
      incHit = incEn && (issue_rd == AW'(i));
      decHit = decEn && (wb_rd == AW'(i));
      if (decHit && (cnt_q[i] == '0)) begin
        underflow_d = underflow_d || !flush;
      end
      if (incHit && !decHit) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (decHit && !incHit && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    // Flush squashes everything in flight, winning over same-cycle issue/writeback.
    if (flush) begin
      for (int i = 0; i < REGISTER_DEPTH; i++) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && downstream_ready && (stall_cycles_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 1; i < REGISTER_DEPTH; i++) begin
      if (cnt_q[i] != '0) begin
        busy_count = busy_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGISTER_DEPTH; i++) begin
        cnt_q[i] <= '0;
      end
      stall_cycles_q <= '0;
      underflow_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      underflow_q    <= underflow_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign underflow_err = underflow_q;

endmodule

// File: doc/decode_hazard_scoreboard.md
Name: decode_hazard_scoreboard

Overview:
- Sequences the decode stage by tracking register-file destinations that are in flight between decode and writeback.
- Holds decode back while an instruction reads a register that still has a pending write.
- Sits beside stage2_decode. Decode supplies the source and destination fields of the current instruction. Writeback supplies retiring destinations. The block returns an accept/stall decision that gates the decode-to-execute handshake.
- Also provides a hazard stall performance counter and a sticky error flag.

Parameters:
- REGISTER_DEPTH, 32, number of architectural registers. Register 0 is never tracked.
- CNT_WIDTH, 2, width of each per-register pending-write counter. Maximum in-flight writes per register is 2**CNT_WIDTH-1.
- STALL_CNT_WIDTH, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode holds a valid instruction this cycle.
- issue_rs1  in  $clog2(REGISTER_DEPTH)  source register 1 address.
- issue_rs1_used  in  1  instruction reads rs1.
- issue_rs2  in  $clog2(REGISTER_DEPTH)  source register 2 address.
- issue_rs2_used  in  1  instruction reads rs2.
- issue_rd  in  $clog2(REGISTER_DEPTH)  destination register address.
- issue_rd_write  in  1  instruction writes rd.
- downstream_ready  in  1  execute stage tready.
- issue_accept  out  1  instruction leaves decode this cycle (combinational).
- stall  out  1  issue is blocked by a hazard (combinational).
- wb_valid  in  1  a register write retires this cycle.
- wb_rd  in  $clog2(REGISTER_DEPTH)  retiring destination register.
- flush  in  1  pipeline squash; all pending state is cleared.
- busy_count  out  $clog2(REGISTER_DEPTH)+1  number of registers with a nonzero pending count (combinational from state).
- stall_cycles  out  STALL_CNT_WIDTH  saturating count of hazard stall cycles.
- underflow_err  out  1  sticky flag: a writeback arrived for a register with a zero pending count.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pending counters = 0, stall_cycles = 0, underflow_err = 0.
  - Combinational outputs follow from this state: busy_count = 0, stall = 0, and issue_accept follows the hazard equation.
- State: one counter per register 1..REGISTER_DEPTH-1. Register 0 reads as 0 permanently and ignores all increments and decrements.
- Hazard terms (all evaluated on registered counter values):
  - raw1 = rs1_used & rs1!=0 & cnt[rs1]!=0
  - raw2 = rs2_used & rs2!=0 & cnt[rs2]!=0
  - full = rd_write & rd!=0 & cnt[rd]==max
  - hazard = raw1 | raw2 | full
- No bypass: a writeback in the same cycle does not release a hazard. Release takes effect the next cycle.
- stall = issue_valid & hazard & ~flush.
- issue_accept = issue_valid & ~hazard & downstream_ready & ~flush. There is zero-cycle latency from the inputs to the decision.
- On issue_accept with rd_write & rd!=0: cnt[rd] increments at the clock edge.
- On wb_valid & wb_rd!=0:
  - If cnt[wb_rd]!=0, it decrements.
  - If cnt[wb_rd]==0, the counter stays at 0 and underflow_err is set. underflow_err stays set until reset.
- Same-cycle increment and decrement on the same register: the counter is unchanged, and the full check uses the pre-edge value.
- Increment and decrement on different registers apply independently in the same cycle.
- flush=1:
  - All counters clear at the next edge, overriding any same-cycle issue or writeback.
  - issue_accept is forced to 0.
  - Writebacks that arrive after the flush for squashed instructions are not allowed by protocol. If one arrives, it sets underflow_err.
- stall_cycles increments by 1 on each cycle with stall & downstream_ready. It holds at all-ones once saturated. Stalls while downstream_ready=0 are not counted.
- The block never modifies issue fields. Decode must hold its instruction stable while issue_valid & ~issue_accept.

Test Plan:
1. Reset, then issue rd=5 write, accepted. Next cycle issue rs1=5 → stall=1, issue_accept=0, busy_count=1. Apply wb_rd=5. The cycle after, issue_accept=1 and busy_count=0.
2. Issue rd=0 write, then rs1=0, rs2=0 reads → never stalls, busy_count stays 0.
3. With CNT_WIDTH=2, issue rd=7 three times → cnt=3. A fourth issue with rd=7 → stall=1 (full). Apply wb_rd=7 in the same cycle → still stalled that cycle, accepted the next cycle.
4. cnt[3]=1. Issue rd=3 and wb_rd=3 in the same cycle → cnt[3] remains 1, busy_count=1.
5. Three registers pending. Assert flush together with issue_valid and wb_valid → issue_accept=0, and busy_count=0 the next cycle. A later wb_rd=4 → underflow_err=1, which stays 1 until rst=0.
6. Hold a RAW stall for 10 cycles with downstream_ready=1 for 6 of them → stall_cycles=6. Pulse rst low mid-stall → all outputs return to their reset values immediately, without waiting for a clock edge.
